// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encodings and default timing for the PLL lock supervisor
package pll_sup_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_LOCK_STABLE    = 1024;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_CNT_W          = 17;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level, cleared to 0 on reset
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, qualifies lock with timeout/retry, gates system reset
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt,
  output logic [2:0] state_dbg
);

  localparam int RET_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

  logic             lock_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retries_q, retries_d;
  logic [7:0]       relock_q, relock_d;
  logic             pll_rst_q;
  logic             sys_rst_n_q;

  sync_2ff u_lock_sync (
    .clk_i   (refclk),
    .rst_n_i (rst_n),
    .d_i     (pll_locked),
    .q_o     (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Lock arriving in WAIT_LOCK or dropping in STABLE both restart the count.
      ST_WAIT_LOCK, ST_STABLE: begin
        if (lock_s != (state_q == ST_STABLE)) begin
          cnt_d   = '0;
          state_d = lock_s ? ST_STABLE : ST_WAIT_LOCK;
        end else if (state_q == ST_STABLE && cnt_q == STABLE_LAST) begin
          cnt_d     = '0;
          retries_d = '0;
          state_d   = ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retries_q == RET_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retries_d = retries_q + RET_W'(1);
            state_d   = ST_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          relock_d = sat_inc8(relock_q);
          cnt_d    = '0;
          state_d  = ST_PLL_RST;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_PLL_RST;
      end
    endcase
    // relock_d is left alone so a lock loss coinciding with soft_reset is still counted.
    if (soft_reset) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      retries_d = '0;
    end
  end

  // Both reset outputs come straight from flops so they cannot glitch on state decode.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      sys_rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = (state_q == ST_RUN);
  assign fail       = (state_q == ST_FAIL);
  assign relock_cnt = relock_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       soft_reset;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [7:0] relock_cnt;
  logic [2:0] state_dbg;

  int checks;
  int errors;
  int n;
  int pulses;
  int hi;
  int lo;
  int fail_at;
  int hi_after;
  int tmo;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .LOCK_STABLE    (8),
    .MAX_RETRIES    (2),
    .CNT_W          (17)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .soft_reset (soft_reset),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .relock_cnt (relock_cnt),
    .state_dbg  (state_dbg)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_sys(input logic want, input int budget, output int cnt);
    cnt = 0;
    while (sys_rst_n !== want && cnt < budget) begin
      @(negedge refclk);
      cnt++;
    end
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, output int cnt);
    cnt = 0;
    while (state_dbg !== want && cnt < budget) begin
      @(negedge refclk);
      cnt++;
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    soft_reset = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("rst_state", state_dbg, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_relock", relock_cnt, 0);

    // Power-up lock: 4-cycle pll_rst, lock at cycle 10, release 11 edges later
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 20) begin
      @(negedge refclk);
      n++;
    end
    chk("t1_pll_rst_len", n, 4);
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    wait_sys(1'b1, 40, n);
    chk("t1_lock_latency", n, 11);
    chk("t1_ready", ready, 1);
    chk("t1_state", state_dbg, 3);

    // Held lock loss in RUN
    pll_locked = 1'b0;
    wait_sys(1'b0, 10, n);
    chk("t4_drop_edges", n, 3);
    chk("t4_relock1", relock_cnt, 1);
    chk("t4_state_pllrst", state_dbg, 0);
    n = 0;
    while (pll_rst && n < 20) begin
      @(negedge refclk);
      n++;
    end
    chk("t4_pll_rst_len", n, 4);
    pll_locked = 1'b1;
    wait_sys(1'b1, 40, n);
    chk("t4_rerun_ready", ready, 1);

    // soft_reset in RUN
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    chk("t5_run_soft_state", state_dbg, 0);
    chk("t5_run_soft_sys", sys_rst_n, 0);
    chk("t5_run_soft_ready", ready, 0);
    chk("t5_run_soft_relock", relock_cnt, 1);
    wait_sys(1'b1, 40, n);
    chk("t5_run_soft_rerun", n, 13);

    // soft_reset on the same edge that sees a lock loss
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    chk("t5_coinc_relock", relock_cnt, 2);
    chk("t5_coinc_state", state_dbg, 0);
    chk("t5_coinc_sys", sys_rst_n, 0);
    wait_sys(1'b1, 40, n);
    chk("t5_coinc_rerun", n, 13);

    // Lock never returns: three pulses of 4 spaced by 32-cycle waits, then FAIL
    pll_locked = 1'b0;
    wait_sys(1'b0, 10, n);
    chk("t2_drop_edges", n, 3);
    chk("t2_relock3", relock_cnt, 3);
    pulses = 0;
    hi = 0;
    lo = 0;
    fail_at = -1;
    hi_after = 0;
    for (int i = 0; i < 160; i++) begin
      if (pll_rst) begin
        if (hi == 0 && pulses > 0) chk("t2_gap", lo, 32);
        if (hi == 0) pulses++;
        hi++;
        lo = 0;
        if (fail_at >= 0) hi_after++;
      end else begin
        if (hi > 0) chk("t2_pulse_len", hi, 4);
        hi = 0;
        lo++;
      end
      if (fail && fail_at < 0) fail_at = i;
      @(negedge refclk);
    end
    chk("t2_pulses", pulses, 3);
    chk("t2_fail_at", fail_at, 108);
    chk("t2_pll_rst_after_fail", hi_after, 0);
    chk("t2_fail", fail, 1);
    chk("t2_sys", sys_rst_n, 0);
    chk("t2_state", state_dbg, 4);

    // soft_reset out of FAIL
    soft_reset = 1'b1;
    pll_locked = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    chk("t5_fail_soft_state", state_dbg, 0);
    chk("t5_fail_soft_fail", fail, 0);
    chk("t5_fail_soft_sys", sys_rst_n, 0);
    chk("t5_fail_soft_pll_rst", pll_rst, 1);
    chk("t5_fail_soft_relock", relock_cnt, 3);
    wait_sys(1'b1, 40, n);
    chk("t5_fail_recover", ready, 1);

    // Losses 4..300: counter saturates
    tmo = 0;
    for (int k = 0; k < 297; k++) begin
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      wait_sys(1'b0, 10, n);
      if (n == 10) tmo++;
      wait_sys(1'b1, 40, n);
      if (n == 40) tmo++;
      if (k == 196) chk("t4_relock_200", relock_cnt, 200);
    end
    chk("t4_sat_timeouts", tmo, 0);
    chk("t4_relock_sat", relock_cnt, 255);

    // Asynchronous rst_n in the middle of STABLE
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    wait_state(3'd2, 20, n);
    @(negedge refclk);
    @(negedge refclk);
    chk("t6_pre_state", state_dbg, 2);
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_state", state_dbg, 0);
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_sys", sys_rst_n, 0);
    chk("t6_ready", ready, 0);
    chk("t6_relock", relock_cnt, 0);
    pll_locked = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;

    // One-cycle glitch at 5 stable highs restarts qualification
    wait_state(3'd1, 10, n);
    chk("t3_wait_entry", n, 4);
    pll_locked = 1'b1;
    wait_state(3'd2, 10, n);
    chk("t3_stable_entry", n, 3);
    repeat (4) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    @(negedge refclk);
    @(negedge refclk);
    chk("t3_back_to_wait", state_dbg, 1);
    @(negedge refclk);
    chk("t3_restable", state_dbg, 2);
    n = 4;
    while (!sys_rst_n && n < 40) begin
      @(negedge refclk);
      n++;
    end
    chk("t3_run_latency", n, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
